// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/halt sequencing for a 5-stage core.
// Define HAZARD_PERF_EN to add saturating stall/flush/load-use counters.
module hazard_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_memRd,
  input  logic       mem_ren,
  input  logic       mem_wen,
  input  logic       dhit,
  input  logic       ihit,
  input  logic       mem_brtaken,
  input  logic       wb_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       halted,
  output logic [1:0] state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] lu_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    REDIR  = 2'd2,
    HALTED = 2'd3
  } stateT;

  stateT stateQ, stateNext;
  logic  dataWait;
  logic  loadUse;
  logic  luStall;

  assign dataWait = (mem_ren | mem_wen) & ~dhit;
  assign loadUse  = ex_memRd & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign state    = stateQ;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    luStall     = 1'b0;
    stateNext   = stateQ;

    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      stateNext   = RUN;
    end else if (stateQ == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (wb_halt) begin
      // Freeze everything on the halt cycle; lower-priority hazards are dropped.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stateNext = HALTED;
    end else if (dataWait) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      stateNext   = DWAIT;
    end else if (mem_brtaken && stateQ != REDIR) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      stateNext   = REDIR;
    end else if (stateQ == REDIR) begin
      if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end else begin
        stateNext = RUN;
      end
    end else if (stateQ == DWAIT) begin
      stateNext = RUN;
    end else if (loadUse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      luStall    = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stateQ <= RUN;
    else     stateQ <= stateNext;
  end

`ifdef HAZARD_PERF_EN
  logic stallEvt;
  logic flushEvt;

  assign stallEvt = ~pc_en & (stateQ != HALTED);
  assign flushEvt = (stateNext == REDIR) & (stateQ != REDIR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
      lu_cnt    <= 16'd0;
    end else begin
      if (stallEvt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flushEvt && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (luStall && lu_cnt != 16'hFFFF)     lu_cnt    <= lu_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a scoreboard of expected output vectors.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memRd, mem_ren, mem_wen, dhit, ihit, mem_brtaken, wb_halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, lu_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] e;
    logic [11:0] m;
    string       tag;
  } expT;
  expT sb[$];

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_memRd(ex_memRd),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .dhit(dhit), .ihit(ihit),
    .mem_brtaken(mem_brtaken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
    .state(state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
`endif
  );

  // {pc,ifid,idex,exmem,memwb enables}, {ifid,idex,exmem,memwb flushes}, halted, state
  function automatic logic [11:0] mk(input logic [4:0] en, input logic [3:0] fl,
                                     input logic h, input logic [1:0] st);
    return {en, fl, h, st};
  endfunction

  function automatic logic [11:0] observed();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, state};
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_memRd = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; dhit = 1'b0; ihit = 1'b1;
    mem_brtaken = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic step(input logic [11:0] e, input logic [11:0] m, input string tag);
    expT x;
    expT y;
    x.e = e; x.m = m; x.tag = tag;
    sb.push_back(x);
    @(negedge CLK);
    y = sb.pop_front();
    checks++;
    assert ((observed() & y.m) === (y.e & y.m)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (mask %h)", y.tag, observed() & y.m, y.e & y.m, y.m);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [11:0] ALL = 12'hFFF;

  initial begin
    logic [11:0] rstV, lu, dw0, dw1, hlt;
    rstV = mk(5'b00000, 4'b1111, 1'b0, 2'd0);
    lu   = mk(5'b00111, 4'b0100, 1'b0, 2'd0);
    dw0  = mk(5'b00001, 4'b0001, 1'b0, 2'd0);
    dw1  = mk(5'b00001, 4'b0001, 1'b0, 2'd1);
    hlt  = mk(5'b00000, 4'b0000, 1'b1, 2'd3);

    RST = 1'b1;
    idle();
    step(rstV, ALL, "reset");
    RST = 1'b0;
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "run_idle");

    ex_memRd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    step(lu, ALL, "loaduse_rs");
    idle();
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "loaduse_clear");
    ex_memRd = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    step(lu, ALL, "loaduse_rt");
    id_rt = 5'd9;
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "load_nomatch");
    ex_rt = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "load_r0");
    idle();
    ihit = 1'b0;
    step(mk(5'b01111, 4'b1000, 1'b0, 2'd0), ALL, "imiss_run");

    idle();
    mem_ren = 1'b1; dhit = 1'b0;
    step(dw0, ALL, "dwait_c1");
    step(dw1, ALL, "dwait_c2");
    step(dw1, ALL, "dwait_c3");
    dhit = 1'b1;
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd1), ALL, "dwait_done");
    idle();
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "dwait_back_run");

    mem_wen = 1'b1; dhit = 1'b0; mem_brtaken = 1'b1;
    step(dw0, ALL, "br_in_wait_c1");
    step(dw1, ALL, "br_in_wait_c2");
    dhit = 1'b1;
    step(mk(5'b11111, 4'b1110, 1'b0, 2'd1), ALL, "br_flush");
    idle();
    ihit = 1'b0;
    step(mk(5'b01111, 4'b1000, 1'b0, 2'd2), ALL, "redir_miss1");
    step(mk(5'b01111, 4'b1000, 1'b0, 2'd2), ALL, "redir_miss2");
    ihit = 1'b1;
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd2), ALL, "redir_hit");
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "redir_back_run");

    wb_halt = 1'b1; mem_brtaken = 1'b1;
    step(mk(5'b00000, 4'b0000, 1'b0, 2'd0), 12'h007, "halt_cycle");
    for (int i = 0; i < 10; i++) begin
      idle();
      mem_brtaken = i[0]; ihit = i[1]; mem_ren = i[2]; ex_memRd = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
      step(hlt, ALL, "halted_hold");
    end
    idle();
    RST = 1'b1;
    step(rstV, ALL, "halt_reset");
    RST = 1'b0;
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "halt_reset_run");

    mem_ren = 1'b1; dhit = 1'b0;
    step(dw0, ALL, "rst_dw_c1");
    step(dw1, ALL, "rst_dw_c2");
    RST = 1'b1;
    step(rstV, ALL, "rst_in_dwait");
    RST = 1'b0;
    idle();
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "rst_dw_no_stall");

    mem_brtaken = 1'b1;
    step(mk(5'b11111, 4'b1110, 1'b0, 2'd0), ALL, "br_run");
    idle();
    ihit = 1'b0;
    step(mk(5'b01111, 4'b1000, 1'b0, 2'd2), ALL, "redir_pre_rst");
    RST = 1'b1;
    step(rstV, ALL, "rst_in_redir");
    RST = 1'b0;
    idle();
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd0), ALL, "rst_redir_no_stall");

`ifdef HAZARD_PERF_EN
    RST = 1'b1;
    step(rstV, ALL, "perf_reset");
    chk16("stall_cnt_reset", stall_cnt, 16'd0);
    chk16("flush_cnt_reset", flush_cnt, 16'd0);
    chk16("lu_cnt_reset", lu_cnt, 16'd0);
    RST = 1'b0;
    mem_brtaken = 1'b1;
    step(mk(5'b11111, 4'b1110, 1'b0, 2'd0), ALL, "perf_br");
    idle();
    step(mk(5'b11111, 4'b0000, 1'b0, 2'd2), ALL, "perf_redir_hit");
    ex_memRd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    step(lu, ALL, "perf_lu");
    idle();
    ihit = 1'b0;
    repeat (70000) @(posedge CLK);
    @(negedge CLK);
    chk16("stall_cnt_sat", stall_cnt, 16'hFFFF);
    chk16("flush_cnt_one", flush_cnt, 16'd1);
    chk16("lu_cnt_one", lu_cnt, 16'd1);
    RST = 1'b1;
    #1;
    chk16("stall_cnt_clr", stall_cnt, 16'd0);
    chk16("flush_cnt_clr", flush_cnt, 16'd0);
    chk16("lu_cnt_clr", lu_cnt, 16'd0);
    RST = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
